// File: rtl/dram_port_arbiter_pkg.sv
// Shared types for the DRAM port arbiter: arbiter state encoding, record
// number / record payload types and the DRAM base address of record 0.
package dram_port_arbiter_pkg;

    localparam logic [16:0] DRAM_BASE  = 17'h10000;
    localparam int          DATA_DIR_W = 57;

    typedef logic [7:0]            data_no_t;
    typedef logic [DATA_DIR_W-1:0] data_dir_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        RESP
    } ARB_STATE;

endpackage

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite DRAM port between two clients,
// one 64-bit record access in flight at a time, one-cycle response pulse.
module dram_port_arbiter
    import dram_port_arbiter_pkg::*;
#(
    parameter int                ADDR_W    = 17,
    parameter int                DATA_W    = 64,
    parameter logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(DRAM_BASE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    input  logic [1:0]             req_write,
    input  data_no_t [1:0]         req_no,
    input  logic [1:0][DATA_W-1:0] req_wdata,
    output logic [1:0]             req_ready,
    output logic [1:0]             rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic                   ar_valid,
    output logic [ADDR_W-1:0]      ar_addr,
    input  logic                   ar_ready,
    input  logic                   r_valid,
    input  logic [DATA_W-1:0]      r_data,
    input  logic [1:0]             r_resp,
    output logic                   r_ready,
    output logic                   aw_valid,
    output logic [ADDR_W-1:0]      aw_addr,
    input  logic                   aw_ready,
    output logic                   w_valid,
    output logic [DATA_W-1:0]      w_data,
    input  logic                   w_ready,
    input  logic                   b_valid,
    input  logic [1:0]             b_resp,
    output logic                   b_ready
);

    // Every AXI channel is valid/ready: a beat transfers on a rising clk edge
    // where both are high; valid-side signals stay stable until that edge.

    ARB_STATE          r_state;
    logic              r_client;
    logic              r_write;
    logic              r_err;
    logic              r_last_grant;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic              w_grant;
    logic              w_gnt_id;

    // On a tie the client that did not win last time goes next.
    always_comb begin
        w_gnt_id = req_valid[1];
        if (req_valid == 2'b11) begin
            w_gnt_id = ~r_last_grant;
        end
        w_grant = (r_state == IDLE) && (req_valid != 2'b00);
    end

    assign req_ready = w_grant ? {w_gnt_id, ~w_gnt_id} : 2'b00;

    assign ar_valid  = (r_state == RD_ADDR);
    assign r_ready   = (r_state == RD_DATA);
    assign aw_valid  = (r_state == WR_ADDR);
    assign w_valid   = (r_state == WR_DATA);
    assign b_ready   = (r_state == WR_RESP);
    assign ar_addr   = r_addr;
    assign aw_addr   = r_addr;
    assign w_data    = r_wdata;
    assign rsp_valid = (r_state == RESP) ? {r_client, ~r_client} : 2'b00;
    assign rsp_rdata = (r_state == RESP && !r_write) ? r_rdata : '0;
    assign rsp_err   = (r_state == RESP) ? r_err : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_client     <= 1'b0;
            r_write      <= 1'b0;
            r_err        <= 1'b0;
            r_last_grant <= 1'b1;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_client     <= w_gnt_id;
                        r_last_grant <= w_gnt_id;
                        r_write      <= req_write[w_gnt_id];
                        r_addr       <= ADDR_BASE + ADDR_W'({req_no[w_gnt_id], 3'b000});
                        r_wdata      <= req_wdata[w_gnt_id];
                        r_err        <= 1'b0;
                        r_state      <= req_write[w_gnt_id] ? WR_ADDR : RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (ar_ready) begin
                        r_state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (r_valid) begin
                        r_rdata <= r_data;
                        r_err   <= (r_resp != 2'b00);
                        r_state <= RESP;
                    end
                end
                WR_ADDR: begin
                    if (aw_ready) begin
                        r_state <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (w_ready) begin
                        r_state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (b_valid) begin
                        r_err   <= (b_resp != 2'b00);
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter: the bench plays both clients and the
// DRAM slave, inputs change and outputs are sampled around the falling edge.
module tb_dram_port_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_write;
    logic [1:0][7:0]  req_no;
    logic [1:0][63:0] req_wdata;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic [63:0]      rsp_rdata;
    logic             rsp_err;
    logic             ar_valid;
    logic [16:0]      ar_addr;
    logic             ar_ready;
    logic             r_valid;
    logic [63:0]      r_data;
    logic [1:0]       r_resp;
    logic             r_ready;
    logic             aw_valid;
    logic [16:0]      aw_addr;
    logic             aw_ready;
    logic             w_valid;
    logic [63:0]      w_data;
    logic             w_ready;
    logic             b_valid;
    logic [1:0]       b_resp;
    logic             b_ready;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    dram_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_no    (req_no),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ar_valid  (ar_valid),
        .ar_addr   (ar_addr),
        .ar_ready  (ar_ready),
        .r_valid   (r_valid),
        .r_data    (r_data),
        .r_resp    (r_resp),
        .r_ready   (r_ready),
        .aw_valid  (aw_valid),
        .aw_addr   (aw_addr),
        .aw_ready  (aw_ready),
        .w_valid   (w_valid),
        .w_data    (w_data),
        .w_ready   (w_ready),
        .b_valid   (b_valid),
        .b_resp    (b_resp),
        .b_ready   (b_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic dram_defaults();
        ar_ready = 1'b1;
        r_valid  = 1'b1;
        r_resp   = 2'b00;
        aw_ready = 1'b1;
        w_ready  = 1'b1;
        b_valid  = 1'b1;
        b_resp   = 2'b00;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ar_valid"},  ar_valid,  0);
        check({tag, " aw_valid"},  aw_valid,  0);
        check({tag, " w_valid"},   w_valid,   0);
        check({tag, " r_ready"},   r_ready,   0);
        check({tag, " b_ready"},   b_ready,   0);
        check({tag, " rsp_valid"}, rsp_valid, 0);
        check({tag, " rsp_rdata"}, rsp_rdata, 0);
        check({tag, " rsp_err"},   rsp_err,   0);
        check({tag, " ar_addr"},   ar_addr,   0);
        check({tag, " aw_addr"},   aw_addr,   0);
        check({tag, " w_data"},    w_data,    0);
    endtask

    // Returns cycles from grant to the response pulse, 0 if none within max_k.
    task automatic wait_rsp(input int max_k, output int lat);
        lat = 0;
        for (int k = 1; k <= max_k; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 2'b00;
            #1;
            if (rsp_valid != 2'b00) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int pulses;
        int grants;
        int last_rsp;
        logic [1:0] busy;

        rst       = 1'b1;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_no    = '0;
        req_wdata = '0;
        r_data    = '0;
        dram_defaults();

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        check("reset req_ready", req_ready, 2'b00);

        // Single read, client 0, no 5
        rst       = 1'b0;
        req_valid = 2'b01;
        req_write = 2'b00;
        req_no[0] = 8'h05;
        r_data    = 64'h0123_4567_89AB_CDEF;
        #1;
        check("rd grant", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check("rd ar_valid", ar_valid, 1);
        check("rd ar_addr", ar_addr, 17'h10028);
        check("rd no rsp yet", rsp_valid, 2'b00);
        @(negedge clk);
        #1;
        check("rd r_ready", r_ready, 1);
        check("rd ar_valid low", ar_valid, 0);
        @(negedge clk);
        #1;
        check("rd rsp_valid T+3", rsp_valid, 2'b01);
        check("rd rsp_rdata", rsp_rdata, 64'h0123_4567_89AB_CDEF);
        check("rd rsp_err", rsp_err, 0);
        @(negedge clk);
        #1;
        check("rd rsp one pulse", rsp_valid, 2'b00);

        // Single write, client 1, no FF
        req_valid    = 2'b10;
        req_write    = 2'b10;
        req_no[1]    = 8'hFF;
        req_wdata[1] = 64'hA5A5;
        #1;
        check("wr grant", req_ready, 2'b10);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check("wr aw_valid", aw_valid, 1);
        check("wr aw_addr", aw_addr, 17'h107F8);
        @(negedge clk);
        #1;
        check("wr w_valid", w_valid, 1);
        check("wr w_data", w_data, 64'hA5A5);
        @(negedge clk);
        #1;
        check("wr b_ready", b_ready, 1);
        @(negedge clk);
        #1;
        check("wr rsp_valid T+4", rsp_valid, 2'b10);
        check("wr rsp_rdata", rsp_rdata, 0);
        check("wr rsp_err", rsp_err, 0);

        // Error response on a client 0 write, then a request raised in RESP
        @(negedge clk);
        b_resp       = 2'b10;
        req_valid    = 2'b01;
        req_write    = 2'b01;
        req_no[0]    = 8'h03;
        req_wdata[0] = 64'h1111_2222_3333_4444;
        #1;
        check("err grant", req_ready, 2'b01);
        wait_rsp(10, lat);
        check("err latency", lat, 4);
        check("err rsp_valid", rsp_valid, 2'b01);
        check("err rsp_err", rsp_err, 1);
        b_resp    = 2'b00;
        req_valid = 2'b10;
        req_write = 2'b00;
        req_no[1] = 8'h01;
        r_data    = 64'h0000_0000_0000_0042;
        #1;
        check("resp no grant", req_ready, 2'b00);
        @(negedge clk);
        #1;
        check("after resp grant", req_ready, 2'b10);
        wait_rsp(8, lat);
        check("after resp latency", lat, 3);
        check("after resp rsp_valid", rsp_valid, 2'b10);
        check("after resp rdata", rsp_rdata, 64'h42);

        // Backpressure: ar_ready low 5 cycles, r_valid 3 more
        @(negedge clk);
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        r_data    = 64'hDEAD_BEEF_0000_1111;
        req_valid = 2'b01;
        req_write = 2'b00;
        req_no[0] = 8'h10;
        #1;
        check("bp grant", req_ready, 2'b01);
        pulses = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 2'b00;
            ar_ready = (k >= 6);
            r_valid  = (k >= 10);
            #1;
            if (k <= 6) begin
                check($sformatf("bp ar_valid k%0d", k), ar_valid, 1);
                check($sformatf("bp ar_addr k%0d", k), ar_addr, 17'h10080);
            end
            if (k == 11) begin
                check("bp rsp_valid", rsp_valid, 2'b01);
                check("bp rsp_rdata", rsp_rdata, 64'hDEAD_BEEF_0000_1111);
            end
            if (rsp_valid != 2'b00) pulses++;
        end
        check("bp one pulse", pulses, 1);
        dram_defaults();

        // Tie from reset: both clients read continuously
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
        busy = 2'b00;
        grants = 0;
        last_rsp = -1;
        req_write = 2'b00;
        for (int c = 0; c < 40; c++) begin
            req_valid = ~busy;
            #1;
            for (int i = 0; i < 2; i++) begin
                if (req_ready[i]) begin
                    check($sformatf("tie grant %0d", grants), req_ready, exp_q.pop_front());
                    if (grants > 0) check($sformatf("tie prior rsp %0d", grants), last_rsp, 1 - i);
                    busy[i] = 1'b1;
                    grants++;
                end
                if (rsp_valid[i]) begin
                    last_rsp = i;
                    busy[i] = 1'b0;
                end
            end
            if (grants == 4) break;
            @(negedge clk);
        end
        check("tie grant count", grants, 4);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (5) @(negedge clk);

        // Reset while in WR_DATA with a client 1 read pending
        w_ready      = 1'b0;
        req_valid    = 2'b01;
        req_write    = 2'b01;
        req_no[0]    = 8'h02;
        req_wdata[0] = 64'h1234;
        #1;
        check("rst wr grant", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b10;
        req_write = 2'b00;
        req_no[1] = 8'h07;
        r_data    = 64'hCAFE_F00D_1234_5678;
        #1;
        check("rst stall", req_ready, 2'b00);
        check("rst aw_valid", aw_valid, 1);
        @(negedge clk);
        #1;
        check("rst w_valid", w_valid, 1);
        check("rst stall wr_data", req_ready, 2'b00);
        rst = 1'b1;
        dram_defaults();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        check("midrst grant c1", req_ready, 2'b10);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check("midrst ar_addr", ar_addr, 17'h10038);
        for (int k = 0; k < 6 && rsp_valid == 2'b00; k++) begin
            @(negedge clk);
            #1;
        end
        check("midrst rsp_valid", rsp_valid, 2'b10);
        check("midrst rsp_rdata", rsp_rdata, 64'hCAFE_F00D_1234_5678);
        check("midrst rsp_err", rsp_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the single AXI4-Lite DRAM port between two requesters: client 0, the main pattern/action engine, and client 1, the scrub/prefetch engine.
- Each client issues one read or write of one 64-bit Data_Dir word, addressed by Data_No.
- Round-robin arbitration with at most one DRAM transaction in flight.
- The result is returned to the granted client as a one-cycle response pulse.

Parameters:
- ADDR_W, 17, DRAM byte-address width.
- DATA_W, 64, DRAM data width. One Data_Dir record is packed in the low 57 bits.
- ADDR_BASE, 17'h10000, byte address of record 0. Record stride is 8 bytes.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-client request; bit i is client i
- req_write  in  2  per-client request type: 1 = write, 0 = read
- req_no  in  2x8  per-client Data_No
- req_wdata  in  2xDATA_W  per-client write data
- req_ready  out  2  one-hot, one-cycle pulse: request accepted
- rsp_valid  out  2  one-hot, one-cycle pulse: transaction complete
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid
- rsp_err  out  1  AXI resp was non-zero; valid with rsp_valid
- ar_valid/ar_addr/ar_ready  out/out/in  1/ADDR_W/1  read address channel
- r_valid/r_data/r_resp/r_ready  in/in/in/out  1/DATA_W/2/1  read data channel
- aw_valid/aw_addr/aw_ready  out/out/in  1/ADDR_W/1  write address channel
- w_valid/w_data/w_ready  out/out/in  1/DATA_W/1  write data channel
- b_valid/b_resp/b_ready  in/in/out  1/2/1  write response channel

Behaviour:
- Clocking and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - last_grant = 1, so client 0 wins the first tie.
- Client rule: a client holds req_* stable while req_valid is high and req_ready has not pulsed. A client deasserts req_valid the cycle after req_ready.
- IDLE, one requester: grant it. req_ready[i] is high combinationally in the same cycle.
- IDLE, both requesting: grant the client != last_grant. last_grant updates on every grant.
- On grant, register the following:
  - client id
  - write flag
  - address = ADDR_BASE + {req_no, 3'b000}, computed in ADDR_W bits; no overflow is possible for 8-bit no
  - wdata
- Next state after grant: RD_ADDR for a read, WR_ADDR for a write.
- Read path:
  - RD_ADDR: ar_valid = 1 and ar_addr is held until ar_ready is sampled high. Then go to RD_DATA.
  - RD_DATA: r_ready = 1. On r_valid, capture r_data and err = (r_resp != 0), then go to RESP.
  - r_valid seen in RD_ADDR is ignored.
- Write path:
  - WR_ADDR: aw_valid = 1 until aw_ready. Then go to WR_DATA.
  - WR_DATA: w_valid = 1 and w_data held until w_ready. Then go to WR_RESP.
  - WR_RESP: b_ready = 1. On b_valid, err = (b_resp != 0), then go to RESP.
- RESP (one cycle):
  - rsp_valid[client] = 1.
  - rsp_rdata = captured data for reads, 0 for writes.
  - rsp_err = err.
  - Next state is IDLE. No grant is issued in RESP.
- Minimum latency with all ready/valid inputs high:
  - Read: grant at T, AR handshake T+1, R handshake T+2, rsp_valid T+3.
  - Write: grant T, AW T+1, W T+2, B T+3, rsp_valid T+4.
- All AXI valid outputs and rsp_* come straight from state/registers. req_ready is the only combinational output.
- Requests arriving outside IDLE are stalled with req_ready = 0. They are never dropped.
- A request raised in the RESP cycle is granted in the following IDLE cycle.
- Reset mid-transaction: the next cycle returns to IDLE with all outputs 0 and the in-flight transaction abandoned. The DRAM model is reset alongside.
- No timeout; a missing DRAM handshake stalls the arbiter indefinitely.

Decomposition:
- Shared usertype package additions:
  - typedef enum logic [2:0] ARB_STATE {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, RESP}
  - localparam DRAM_BASE = 17'h10000
- The existing Data_No and Data_Dir types are reused for req_no and wdata packing.
- Single module; no sub-module is needed. The round-robin picker stays an internal always_comb block.

Test Plan:
- Single read: client0 read, no=8'h05, DRAM returns 64'h0123_4567_89AB_CDEF with resp 0, all ready high -> ar_addr = 17'h10028; rsp_valid = 2'b01 at T+3; rsp_rdata = 64'h0123_4567_89AB_CDEF; rsp_err = 0.
- Single write: client1 write, no=8'hFF, wdata = 64'hA5A5 -> aw_addr = 17'h107F8, w_data = 64'hA5A5, rsp_valid = 2'b10 at T+4, rsp_rdata = 0.
- Tie: both clients request reads continuously, from reset -> grants alternate 0,1,0,1; each req_ready is preceded by the other client's rsp_valid.
- Backpressure: ar_ready held low 5 cycles, r_valid delayed 3 more -> ar_valid and ar_addr stay stable throughout; exactly one rsp_valid pulse.
- Error: b_resp = 2'b10 on a client0 write -> rsp_err = 1 together with rsp_valid = 2'b01.
- Reset: rst asserted while in WR_DATA -> next cycle all outputs 0 and state IDLE; a pending client1 read is then served with a normal response.
